// File: rtl/board_io_conditioner.sv
// board_io_conditioner: board-side conditioning between FPGA pins and the core.
// Sequences the core reset from the reset key and PLL lock, synchronises the
// slide switches and debounces the push-buttons with one-cycle press pulses.
// Optional feature macro: BOARD_IO_DEBOUNCE_EN (defined = counter-based key
// debouncers; undefined = keys only re-registered once after synchronisation).
module board_io_conditioner #(
    parameter int N_KEY        = 3,
    parameter int N_SW         = 10,
    parameter int DEBOUNCE_CYC = 250000,
    parameter int RST_HOLD_CYC = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_pll_locked,
    input  logic [N_KEY-1:0]  i_key,
    input  logic [N_SW-1:0]   i_sw,
    output logic              o_core_reset_n,
    output logic [31:0]       o_io_key,
    output logic [31:0]       o_io_sw,
    output logic [N_KEY-1:0]  o_key_press,
    output logic              o_ready
);

    localparam int HOLD_W = (RST_HOLD_CYC > 1) ? $clog2(RST_HOLD_CYC) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYC - 1);

    typedef enum logic {
        S_HOLD = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    logic              lock_meta_q, lock_sync_q;
    logic [N_KEY-1:0]  key_meta_q, key_sync_q;
    logic [N_SW-1:0]   sw_meta_q, sw_sync_q;

    state_t            state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              core_reset_n_q, core_reset_n_d;
    logic              ready_q, ready_d;

    logic [N_KEY-1:0]  stable_q, stable_d;
    logic [N_KEY-1:0]  press_q, press_d;
    logic              run_steady;

    // Two-flop synchronisers; idle keys are high (released), lock starts lost
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            lock_meta_q <= 1'b0;
            lock_sync_q <= 1'b0;
            key_meta_q  <= '1;
            key_sync_q  <= '1;
            sw_meta_q   <= '0;
            sw_sync_q   <= '0;
        end else begin
            lock_meta_q <= i_pll_locked;
            lock_sync_q <= lock_meta_q;
            key_meta_q  <= i_key;
            key_sync_q  <= key_meta_q;
            sw_meta_q   <= i_sw;
            sw_sync_q   <= sw_meta_q;
        end
    end

    // Reset sequencer next state: count stable lock in HOLD, fall back on lock loss
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            S_HOLD: begin
                if (!lock_sync_q) begin
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d    = S_RUN;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            S_RUN: begin
                if (!lock_sync_q) begin
                    state_d    = S_HOLD;
                    hold_cnt_d = '0;
                end
            end
            default: begin
                state_d    = S_HOLD;
                hold_cnt_d = '0;
            end
        endcase
        core_reset_n_d = (state_d == S_RUN);
        ready_d        = (state_d == S_RUN);
    end

    // Sequencer state and its registered outputs; async clear asserts core reset
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q        <= S_HOLD;
            hold_cnt_q     <= '0;
            core_reset_n_q <= 1'b0;
            ready_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            hold_cnt_q     <= hold_cnt_d;
            core_reset_n_q <= core_reset_n_d;
            ready_q        <= ready_d;
        end
    end

`ifdef BOARD_IO_DEBOUNCE_EN
    localparam int DEB_W = $clog2(DEBOUNCE_CYC);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYC - 1);

    logic [DEB_W-1:0] deb_cnt_q [N_KEY];
    logic [DEB_W-1:0] deb_cnt_d [N_KEY];

    // Accept a key change only after it has differed from the stable level long enough
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < N_KEY; i++) begin
            deb_cnt_d[i] = '0;
            if (key_sync_q[i] != stable_q[i]) begin
                if (deb_cnt_q[i] == DEB_LAST) begin
                    stable_d[i] = key_sync_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Debounce counters, cleared on reset
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < N_KEY; i++) begin
                deb_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_KEY; i++) begin
                deb_cnt_q[i] <= deb_cnt_d[i];
            end
        end
    end
`else
    // Without debouncing the stable level is simply the synchronised key, one cycle later
    always_comb begin
        stable_d = key_sync_q;
    end
`endif

    // Press pulses fire on the stable falling edge, only while the core stays in RUN
    always_comb begin
        run_steady = (state_q == S_RUN) && (state_d == S_RUN);
        press_d    = stable_q & ~stable_d & {N_KEY{run_steady}};
    end

    // Stable key levels and press pulses
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            stable_q <= '1;
            press_q  <= '0;
        end else begin
            stable_q <= stable_d;
            press_q  <= press_d;
        end
    end

    // Zero-extend the conditioned words to the core's 32-bit I/O registers
    always_comb begin
        o_io_key              = '0;
        o_io_key[N_KEY-1:0]   = stable_q;
        o_io_sw               = '0;
        o_io_sw[N_SW-1:0]     = sw_sync_q;
        o_core_reset_n        = core_reset_n_q;
        o_ready               = ready_q;
        o_key_press           = press_q;
    end

endmodule

// File: tb/tb_board_io_conditioner.sv
// Directed testbench for board_io_conditioner (N_KEY=3, N_SW=10,
// DEBOUNCE_CYC=4, RST_HOLD_CYC=8). Expectations follow BOARD_IO_DEBOUNCE_EN.
module tb_board_io_conditioner;

    localparam int N_KEY        = 3;
    localparam int N_SW         = 10;
    localparam int DEBOUNCE_CYC = 4;
    localparam int RST_HOLD_CYC = 8;
    localparam int REL_LAT      = 2 + RST_HOLD_CYC;

`ifdef BOARD_IO_DEBOUNCE_EN
    localparam bit DEB_EN  = 1'b1;
    localparam int KEY_LAT = 2 + DEBOUNCE_CYC;
`else
    localparam bit DEB_EN  = 1'b0;
    localparam int KEY_LAT = 3;
`endif

    logic              clk;
    logic              i_reset;
    logic              i_pll_locked;
    logic [N_KEY-1:0]  i_key;
    logic [N_SW-1:0]   i_sw;
    logic              o_core_reset_n;
    logic [31:0]       o_io_key;
    logic [31:0]       o_io_sw;
    logic [N_KEY-1:0]  o_key_press;
    logic              o_ready;

    int vectors;
    int miscompares;

    board_io_conditioner #(
        .N_KEY        (N_KEY),
        .N_SW         (N_SW),
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .RST_HOLD_CYC (RST_HOLD_CYC)
    ) dut (
        .i_clk          (clk),
        .i_reset        (i_reset),
        .i_pll_locked   (i_pll_locked),
        .i_key          (i_key),
        .i_sw           (i_sw),
        .o_core_reset_n (o_core_reset_n),
        .o_io_key       (o_io_key),
        .o_io_sw        (o_io_sw),
        .o_key_press    (o_key_press),
        .o_ready        (o_ready)
    );

    // 100 MHz free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // One clock edge, then settle so outputs are sampled away from the edge
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        i_reset      = 1'b0;
        i_pll_locked = 1'b1;
        i_key        = '1;
        i_sw         = '0;
        repeat (3) tick();
        vectors++;
        if (o_core_reset_n !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rst_core_n: got %b expected 0", o_core_reset_n);
        end
        vectors++;
        if (o_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rst_ready: got %b expected 0", o_ready);
        end
        vectors++;
        if (o_key_press !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL rst_press: got %b expected 000", o_key_press);
        end
        vectors++;
        if (o_io_key !== 32'h0000_0007) begin
            miscompares++;
            $display("[TB] FAIL rst_io_key: got %h expected 00000007", o_io_key);
        end
        vectors++;
        if (o_io_sw !== 32'h0000_0000) begin
            miscompares++;
            $display("[TB] FAIL rst_io_sw: got %h expected 00000000", o_io_sw);
        end
        i_reset = 1'b1;
        for (int k = 1; k <= REL_LAT; k++) begin
            tick();
            vectors++;
            if (o_core_reset_n !== (k == REL_LAT)) begin
                miscompares++;
                $display("[TB] FAIL release_core_n c%0d: got %b expected %b", k, o_core_reset_n, (k == REL_LAT));
            end
            vectors++;
            if (o_ready !== (k == REL_LAT)) begin
                miscompares++;
                $display("[TB] FAIL release_ready c%0d: got %b expected %b", k, o_ready, (k == REL_LAT));
            end
        end
    endtask

    task automatic test_switches;
        logic [N_SW-1:0] pats [4];
        logic [N_SW-1:0] prev;
        pats[0] = 10'h2A5;
        pats[1] = 10'h15A;
        pats[2] = 10'h3FF;
        pats[3] = 10'h2A5;
        prev = '0;
        for (int p = 0; p < 4; p++) begin
            i_sw = pats[p];
            tick();
            vectors++;
            if (o_io_sw !== {22'd0, prev}) begin
                miscompares++;
                $display("[TB] FAIL sw_hold p%0d: got %h expected %h", p, o_io_sw, {22'd0, prev});
            end
            tick();
            vectors++;
            if (o_io_sw !== {22'd0, pats[p]}) begin
                miscompares++;
                $display("[TB] FAIL sw_update p%0d: got %h expected %h", p, o_io_sw, {22'd0, pats[p]});
            end
            prev = pats[p];
        end
    endtask

    task automatic test_key_bounce;
        logic [9:0] pat;
        logic [9:0] exp_key0;
        logic [9:0] exp_press0;
        pat        = 10'b00_0000_0010;
        exp_key0   = DEB_EN ? 10'h07F : 10'h00B;
        exp_press0 = DEB_EN ? 10'h080 : 10'h014;
        for (int k = 1; k <= 10; k++) begin
            i_key[0] = pat[k-1];
            tick();
            vectors++;
            if (o_io_key !== {29'd0, 2'b11, exp_key0[k-1]}) begin
                miscompares++;
                $display("[TB] FAIL bounce_key c%0d: got %h expected %h", k, o_io_key, {29'd0, 2'b11, exp_key0[k-1]});
            end
            vectors++;
            if (o_key_press !== {2'b00, exp_press0[k-1]}) begin
                miscompares++;
                $display("[TB] FAIL bounce_press c%0d: got %b expected %b", k, o_key_press, {2'b00, exp_press0[k-1]});
            end
        end
        i_key[0] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            vectors++;
            if (o_key_press !== 3'b000) begin
                miscompares++;
                $display("[TB] FAIL release_press c%0d: got %b expected 000", k, o_key_press);
            end
        end
        vectors++;
        if (o_io_key !== 32'h0000_0007) begin
            miscompares++;
            $display("[TB] FAIL release_key: got %h expected 00000007", o_io_key);
        end
    endtask

    task automatic test_glitch;
        logic [31:0] exp_key;
        logic [2:0]  exp_press;
        for (int k = 1; k <= 10; k++) begin
            i_key[1] = (k <= 3) ? 1'b0 : 1'b1;
            tick();
            exp_key   = (!DEB_EN && k >= 3 && k <= 5) ? 32'h0000_0005 : 32'h0000_0007;
            exp_press = (!DEB_EN && k == 3) ? 3'b010 : 3'b000;
            vectors++;
            if (o_io_key !== exp_key) begin
                miscompares++;
                $display("[TB] FAIL glitch_key c%0d: got %h expected %h", k, o_io_key, exp_key);
            end
            vectors++;
            if (o_key_press !== exp_press) begin
                miscompares++;
                $display("[TB] FAIL glitch_press c%0d: got %b expected %b", k, o_key_press, exp_press);
            end
        end
    endtask

    task automatic test_lock_loss;
        i_pll_locked = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            vectors++;
            if (o_core_reset_n !== (k < 3)) begin
                miscompares++;
                $display("[TB] FAIL lockloss_core_n c%0d: got %b expected %b", k, o_core_reset_n, (k < 3));
            end
        end
        vectors++;
        if (o_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL lockloss_ready: got %b expected 0", o_ready);
        end
        i_pll_locked = 1'b1;
        for (int k = 1; k <= REL_LAT; k++) begin
            tick();
            vectors++;
            if (o_core_reset_n !== (k == REL_LAT)) begin
                miscompares++;
                $display("[TB] FAIL relock_core_n c%0d: got %b expected %b", k, o_core_reset_n, (k == REL_LAT));
            end
        end
    endtask

    task automatic test_press_lock_collision;
        i_key[0] = 1'b0;
        for (int k = 1; k <= KEY_LAT; k++) begin
            if (k == KEY_LAT - 2) i_pll_locked = 1'b0;
            tick();
            vectors++;
            if (o_key_press !== 3'b000) begin
                miscompares++;
                $display("[TB] FAIL collide_press c%0d: got %b expected 000", k, o_key_press);
            end
        end
        vectors++;
        if (o_core_reset_n !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL collide_core_n: got %b expected 0", o_core_reset_n);
        end
        vectors++;
        if (o_io_key !== 32'h0000_0006) begin
            miscompares++;
            $display("[TB] FAIL collide_key: got %h expected 00000006", o_io_key);
        end
        i_key[0]     = 1'b1;
        i_pll_locked = 1'b1;
        for (int k = 1; k <= REL_LAT; k++) begin
            tick();
            vectors++;
            if (o_key_press !== 3'b000) begin
                miscompares++;
                $display("[TB] FAIL collide_recover_press c%0d: got %b expected 000", k, o_key_press);
            end
        end
        vectors++;
        if (o_core_reset_n !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL collide_recover_core_n: got %b expected 1", o_core_reset_n);
        end
        vectors++;
        if (o_io_key !== 32'h0000_0007) begin
            miscompares++;
            $display("[TB] FAIL collide_recover_key: got %h expected 00000007", o_io_key);
        end
    endtask

    task automatic test_reset_mid_debounce;
        i_key[2] = 1'b0;
        repeat (KEY_LAT - 2) tick();
        vectors++;
        if (o_io_key !== 32'h0000_0007) begin
            miscompares++;
            $display("[TB] FAIL middeb_key: got %h expected 00000007", o_io_key);
        end
        i_reset = 1'b0;
        #1;
        vectors++;
        if (o_core_reset_n !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL async_core_n: got %b expected 0", o_core_reset_n);
        end
        vectors++;
        if (o_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL async_ready: got %b expected 0", o_ready);
        end
        vectors++;
        if (o_key_press !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL async_press: got %b expected 000", o_key_press);
        end
        vectors++;
        if (o_io_key !== 32'h0000_0007) begin
            miscompares++;
            $display("[TB] FAIL async_key: got %h expected 00000007", o_io_key);
        end
        vectors++;
        if (o_io_sw !== 32'h0000_0000) begin
            miscompares++;
            $display("[TB] FAIL async_sw: got %h expected 00000000", o_io_sw);
        end
        repeat (2) tick();
        i_reset = 1'b1;
        for (int k = 1; k <= REL_LAT; k++) begin
            tick();
            vectors++;
            if (o_core_reset_n !== (k == REL_LAT)) begin
                miscompares++;
                $display("[TB] FAIL rerelease_core_n c%0d: got %b expected %b", k, o_core_reset_n, (k == REL_LAT));
            end
            vectors++;
            if (o_io_key !== ((k >= KEY_LAT) ? 32'h0000_0003 : 32'h0000_0007)) begin
                miscompares++;
                $display("[TB] FAIL rerelease_key c%0d: got %h expected %h", k, o_io_key, ((k >= KEY_LAT) ? 32'h3 : 32'h7));
            end
            vectors++;
            if (o_key_press !== 3'b000) begin
                miscompares++;
                $display("[TB] FAIL rerelease_press c%0d: got %b expected 000", k, o_key_press);
            end
            vectors++;
            if (o_io_sw !== ((k >= 2) ? 32'h0000_02A5 : 32'h0000_0000)) begin
                miscompares++;
                $display("[TB] FAIL rerelease_sw c%0d: got %h expected %h", k, o_io_sw, ((k >= 2) ? 32'h2A5 : 32'h0));
            end
        end
        i_key[2] = 1'b1;
        repeat (10) tick();
        vectors++;
        if (o_io_key !== 32'h0000_0007) begin
            miscompares++;
            $display("[TB] FAIL key2_idle: got %h expected 00000007", o_io_key);
        end
        i_key[2] = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            vectors++;
            if (o_io_key !== ((k >= KEY_LAT) ? 32'h0000_0003 : 32'h0000_0007)) begin
                miscompares++;
                $display("[TB] FAIL key2_accept c%0d: got %h expected %h", k, o_io_key, ((k >= KEY_LAT) ? 32'h3 : 32'h7));
            end
            vectors++;
            if (o_key_press !== ((k == KEY_LAT) ? 3'b100 : 3'b000)) begin
                miscompares++;
                $display("[TB] FAIL key2_press c%0d: got %b expected %b", k, o_key_press, ((k == KEY_LAT) ? 3'b100 : 3'b000));
            end
        end
        i_key[2] = 1'b1;
        repeat (10) tick();
    endtask

    // Scenario sequence
    initial begin
        vectors      = 0;
        miscompares  = 0;
        i_reset      = 1'b0;
        i_pll_locked = 1'b0;
        i_key        = '1;
        i_sw         = '0;
        test_reset();
        test_switches();
        test_key_bounce();
        test_glitch();
        test_lock_loss();
        test_press_lock_collision();
        test_reset_mid_debounce();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
